// File: rtl/data_memory_responder_if.sv
// Load/store port between the CPU memory stage (master) and the data
// memory responder (slave): a valid/ready request channel and a
// valid/ready response channel.
// Optional feature macro: DMEM_BYTE_WRITE_EN adds the req_byte_en lane mask.
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]  req_byte_en;
`endif
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
        output req_byte_en,
`endif
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_error
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
        input  req_byte_en,
`endif
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data memory with a fixed, parameterised response latency.
// One request outstanding at a time; the response is produced LATENCY
// cycles after the request is accepted and held until the initiator takes it.
// Optional feature macro: DMEM_BYTE_WRITE_EN (per-lane store enables).
//
//  state  | meaning
//  IDLE   | ready for a request (req_ready=1)
//  BUSY   | request latched, latency counter running down to zero
//  RESP   | response presented, waiting for resp_ready
module data_memory_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    data_memory_responder_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_count;
    logic                r_write;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_byte_en;
    logic [31:0]         r_rdata;
    logic                r_error;
    logic [31:0]         r_mem [DEPTH];

    logic                w_accept;
    logic                w_enter_resp;
    logic                w_resp_done;
    logic                w_misaligned;
    logic [ADDR_W-1:0]   w_index;
    logic                w_unused_addr;

    // Address bits above the word index are ignored, so the memory wraps.
    assign w_unused_addr = ^bus.req_addr[31:ADDR_W+2];
    assign w_misaligned  = (r_addr[1:0] != 2'b00);
    assign w_index       = r_addr[ADDR_W+1:2];

    // State register; reset returns to IDLE at once, abandoning any request.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_enter_resp   = 1'b0;
        w_resp_done    = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                // Counter is loaded with LATENCY-1 on acceptance, so reaching
                // zero here lands the RESP entry exactly LATENCY edges later.
                if (r_count == 4'd0) begin
                    w_enter_resp = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    w_resp_done  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Latency down-counter: load on acceptance, count down while BUSY.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= 4'd0;
        end else if (w_accept) begin
            r_count <= 4'(LATENCY - 1);
        end else if (r_state == S_BUSY && r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    // Request fields are captured only on the acceptance edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_byte_en <= 4'd0;
        end else if (w_accept) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr[ADDR_W+1:0];
            r_wdata <= bus.req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
            r_byte_en <= bus.req_byte_en;
`else
            r_byte_en <= 4'hF;
`endif
        end
    end

    // Response data/error: set on RESP entry, held, cleared on handshake.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rdata <= 32'd0;
            r_error <= 1'b0;
        end else if (w_enter_resp) begin
            if (w_misaligned) begin
                r_rdata <= 32'd0;
                r_error <= 1'b1;
            end else if (r_write) begin
                r_rdata <= 32'd0;
                r_error <= 1'b0;
            end else begin
                r_rdata <= r_mem[w_index];
                r_error <= 1'b0;
            end
        end else if (w_resp_done) begin
            r_rdata <= 32'd0;
            r_error <= 1'b0;
        end
    end

    // Store commit on RESP entry; contents survive reset.
    always_ff @(posedge i_clock) begin
        if (w_enter_resp && r_write && !w_misaligned) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (r_byte_en[lane]) begin
                    r_mem[w_index][8*lane +: 8] <= r_wdata[8*lane +: 8];
                end
            end
        end
    end

    assign bus.resp_rdata = r_rdata;
    assign bus.resp_error = r_error;
endmodule
